acc_unit: RTL and testbench
===========================

# acc_unit

Parametrised accumulator with ALU operations, status flags and a hardware save/restore stack. It replaces the fixed 8-bit load-only accumulator register in the datapath. It takes one opcode per cycle from the control unit and drives the accumulator value back to the ALU and bus muxes. The save stack lets the controller preserve the accumulator across subroutine-style sequences without using memory cycles.

## Interface
- `WIDTH`, default 8: accumulator and data width in bits, minimum 2.
- `DEPTH`, default 4: save-stack entries, minimum 1.
- `clk`: input, 1 bit. Single clock; all state changes on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `op_valid`: input, 1 bit. Qualifies `op`. When low, the cycle is a NOP.
- `op`: input, 3 bits. Opcode, one of `acc_op_t`.
- `data_in`: input, `WIDTH` bits. Operand for LOAD, ADD, SUB, AND and XOR.
- `data_out`: output, `WIDTH` bits. Registered accumulator value.
- `zero`: output, 1 bit. Set when the accumulator equals 0.
- `neg`: output, 1 bit. Accumulator MSB.
- `carry`: output, 1 bit. Carry-out of the last ADD, or borrow of the last SUB.
- `full`: output, 1 bit. Stack holds `DEPTH` entries.
- `empty`: output, 1 bit. Stack holds 0 entries.
- `err`: output, 1 bit. Sticky flag, set on stack overflow or underflow.
- `clr_err`: input, 1 bit. Synchronous clear of `err`.

## Operation
- Opcodes (`acc_op_t`):
  - NOP = 0
  - LOAD = 1: acc ← data_in
  - ADD = 2: acc ← acc + data_in
  - SUB = 3: acc ← acc − data_in
  - AND = 4: acc ← acc & data_in
  - XOR = 5: acc ← acc ^ data_in
  - PUSH = 6: stack ← acc; acc is unchanged
  - POP = 7: acc ← stack top
- Arithmetic is unsigned and modulo 2^WIDTH. The internal sum is `WIDTH`+1 bits wide.
  - ADD: `carry` = bit `WIDTH` of the sum.
  - SUB: `carry` = 1 if and only if data_in > acc (unsigned borrow).
- `carry` is updated only by ADD and SUB; every other opcode holds it.
- `zero` and `neg` are recomputed from the new accumulator value on every opcode that writes it (LOAD, ADD, SUB, AND, XOR, and a successful POP). They are registered, so they are coherent with `data_out`.
- Stack is a LIFO with a count of 0..`DEPTH`.
  - PUSH when `full`: no state change, `err` ← 1.
  - POP when `empty`: accumulator and flags unchanged, `err` ← 1.
- `err` stays set until `clr_err` is sampled high, or reset.
  - If `clr_err` and a new overflow or underflow occur in the same cycle, the set wins and `err` stays 1.
- With `op_valid` low, the accumulator, flags and stack all hold.

## Timing
- Every opcode completes in one cycle. The result is visible on `data_out` and the flags after the rising edge that samples the op.
- Back-to-back ops are allowed every cycle with no stall.
  - PUSH followed immediately by POP returns the pushed value.
- Reset values, applied asynchronously on `rst_n` going low:
  - `data_out` = 0
  - `zero` = 1
  - `neg` = 0
  - `carry` = 0
  - `full` = 0
  - `empty` = 1
  - `err` = 0
  - stack count = 0
- Reset asserted mid-cycle takes effect immediately. Any op sampled while `rst_n` is low is discarded.
- Reset deassertion is synchronised externally. The first op is sampled on the first rising edge with `rst_n` high.
- `full` and `empty` are registered, derived from the next count.

## Configuration
- `ACC_UNIT_SAT_EN` defined: ADD and SUB saturate.
  - ADD with carry-out yields all ones.
  - SUB with borrow yields 0.
  - `carry` still reports the overflow or borrow.
- Macro undefined: ADD and SUB wrap modulo 2^WIDTH.
- No other behaviour depends on the macro.

## Structure
- Package `acc_pkg` holds:
  - the `acc_op_t` enum (3 bits, encodings as above);
  - the opcode width constant `ACC_OP_W` = 3.
- Sub-module `acc_stack`: parametrised LIFO.
  - Parameters: `WIDTH`, `DEPTH`.
  - Interface: push, pop, wr_data, rd_data, full, empty, ovf, unf.
  - Count uses $clog2(`DEPTH`+1) bits.
- The top level holds the ALU mux, the flag registers and `err`.

## Test plan
All scenarios use `WIDTH` = 8 and `DEPTH` = 4.
- **Reset:** hold `rst_n` low for 2 cycles, then release → `data_out` = 0x00, `zero` = 1, `empty` = 1, `full` = 0, `err` = 0. Pulse `rst_n` low between clock edges → outputs clear before the next edge.
- **Load and add:** LOAD 0xAB, then ADD 0x60.
  - Macro undefined → `data_out` = 0x0B, `carry` = 1.
  - `ACC_UNIT_SAT_EN` defined → `data_out` = 0xFF, `carry` = 1.
- **Subtract:** LOAD 0x10, then SUB 0x20 → `data_out` = 0xF0, `carry` = 1, `neg` = 1 (SAT build: 0x00, `zero` = 1). Then AND 0x0F → 0x00, `zero` = 1, `carry` still 1.
- **Stack fill and drain:** PUSH 0x11, 0x22, 0x33, 0x44 (each via LOAD then PUSH) → `full` = 1. A fifth PUSH → `err` = 1, `full` still 1. Four POPs → 0x44, 0x33, 0x22, 0x11, then `empty` = 1. A fifth POP → `data_out` stays 0x11.
- **Sticky error:** with `err` = 1, drive `clr_err` = 1 together with POP on empty → `err` stays 1. `clr_err` alone → `err` = 0.
- **Qualifier and mid-op reset:** `op_valid` = 0 with `op` = LOAD, `data_in` = 0x55 → no change. Assert LOAD 0xCC with `op_valid` = 1, then pull `rst_n` low 5 ns before the edge → `data_out` = 0x00 and 0xCC is never loaded.

Source files
------------

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - opcode encodings shared by the accumulator unit and its users
//
// Purpose: holds the acc_op_t opcode enum and the opcode width constant.
// Ports:   none (package).
package acc_pkg;

  localparam int ACC_OP_W = 3;

  typedef enum logic [ACC_OP_W-1:0] {
    OP_NOP  = 3'd0,
    OP_LOAD = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_AND  = 3'd4,
    OP_XOR  = 3'd5,
    OP_PUSH = 3'd6,
    OP_POP  = 3'd7
  } acc_op_t;

endpackage

// File: rtl/acc_unit_if.sv
// rtl/acc_unit_if.sv - opcode/result bundle between control unit and accumulator
//
// Purpose: groups the opcode channel and the accumulator result/flag outputs.
// Signals:
//   op_valid, op, data_in, clr_err  : controller -> accumulator
//   data_out, zero, neg, carry      : accumulator value and ALU flags
//   full, empty, err                : save-stack status and sticky error
// Modports: master (controller side), slave (accumulator side).
interface acc_unit_if #(
  parameter int WIDTH = 8
);
  import acc_pkg::*;

  logic             op_valid;
  acc_op_t          op;
  logic [WIDTH-1:0] data_in;
  logic             clr_err;
  logic [WIDTH-1:0] data_out;
  logic             zero;
  logic             neg;
  logic             carry;
  logic             full;
  logic             empty;
  logic             err;

  modport master (
    output op_valid, op, data_in, clr_err,
    input  data_out, zero, neg, carry, full, empty, err
  );

  modport slave (
    input  op_valid, op, data_in, clr_err,
    output data_out, zero, neg, carry, full, empty, err
  );

endinterface

// File: rtl/acc_stack.sv
// rtl/acc_stack.sv - parametrised LIFO used as the accumulator save stack
//
// Purpose: DEPTH-entry LIFO; rejects push when full and pop when empty and
//          flags those attempts on o_ovf / o_unf in the same cycle.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_push, i_pop      : push i_wr_data / pop top entry (never both at once)
//   i_wr_data          : value to push
//   o_rd_data          : current top entry (valid while not empty)
//   o_full, o_empty    : registered occupancy status
//   o_ovf, o_unf       : push-while-full / pop-while-empty this cycle
module acc_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_ovf,
  output logic             o_unf
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic [CW-1:0]    w_count_nxt;
  logic             w_do_push;
  logic             w_do_pop;
  logic [IW-1:0]    w_wr_idx;
  logic [IW-1:0]    w_top_idx;

  assign w_do_push = i_push & ~r_full;
  assign w_do_pop  = i_pop & ~r_empty;
  assign o_ovf     = i_push & r_full;
  assign o_unf     = i_pop & r_empty;

  // Count never exceeds DEPTH-1 when writing and is at least 1 when reading,
  // so the truncated indices always land inside the array.
  assign w_wr_idx  = IW'(r_count);
  assign w_top_idx = IW'(r_count - CW'(1));

  always_comb begin
    w_count_nxt = r_count;
    if (w_do_push) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_do_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[w_top_idx];
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule

// File: rtl/acc_unit.sv
// rtl/acc_unit.sv - accumulator with ALU ops, flags, sticky error and save stack
//
// Purpose: executes one acc_op_t per cycle on the accumulator; PUSH/POP move
//          the accumulator to/from an acc_stack instance.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : acc_unit_if.slave (opcode in, accumulator and flags out)
// Build option: ACC_UNIT_SAT_EN makes ADD/SUB saturate instead of wrapping.
module acc_unit
  import acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  acc_unit_if.slave  bus
);

  logic [WIDTH-1:0] r_acc;
  logic             r_zero;
  logic             r_neg;
  logic             r_carry;
  logic             r_err;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_carry_nxt;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_stk_rd;
  logic             w_full;
  logic             w_empty;
  logic             w_ovf;
  logic             w_unf;

  // Bit WIDTH of the extended difference is the unsigned borrow (data_in > acc).
  assign w_sum  = {1'b0, r_acc} + {1'b0, bus.data_in};
  assign w_diff = {1'b0, r_acc} - {1'b0, bus.data_in};

  always_comb begin
    w_acc_nxt   = r_acc;
    w_carry_nxt = r_carry;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    if (bus.op_valid) begin
      case (bus.op)
        OP_LOAD: w_acc_nxt = bus.data_in;
        OP_ADD: begin
          w_carry_nxt = w_sum[WIDTH];
`ifdef ACC_UNIT_SAT_EN
          w_acc_nxt = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
          w_acc_nxt = w_sum[WIDTH-1:0];
`endif
        end
        OP_SUB: begin
          w_carry_nxt = w_diff[WIDTH];
`ifdef ACC_UNIT_SAT_EN
          w_acc_nxt = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
`else
          w_acc_nxt = w_diff[WIDTH-1:0];
`endif
        end
        OP_AND:  w_acc_nxt = r_acc & bus.data_in;
        OP_XOR:  w_acc_nxt = r_acc ^ bus.data_in;
        OP_PUSH: w_push = 1'b1;
        OP_POP: begin
          w_pop = 1'b1;
          if (!w_empty) begin
            w_acc_nxt = w_stk_rd;
          end
        end
        default: ;
      endcase
    end
  end

  // zero/neg follow w_acc_nxt every cycle; when the accumulator holds they
  // simply reload the same values, keeping them coherent with data_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_zero  <= 1'b1;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_zero  <= (w_acc_nxt == '0);
      r_neg   <= w_acc_nxt[WIDTH-1];
      r_carry <= w_carry_nxt;
      // A new overflow/underflow beats a simultaneous clear.
      if (w_ovf || w_unf) begin
        r_err <= 1'b1;
      end else if (bus.clr_err) begin
        r_err <= 1'b0;
      end
    end
  end

  acc_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (r_acc),
    .o_rd_data (w_stk_rd),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_ovf     (w_ovf),
    .o_unf     (w_unf)
  );

  assign bus.data_out = r_acc;
  assign bus.zero     = r_zero;
  assign bus.neg      = r_neg;
  assign bus.carry    = r_carry;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_acc_unit.sv
// tb/tb_acc_unit.sv - self-checking bench for acc_unit (WIDTH=8, DEPTH=4)
module tb_acc_unit;
  import acc_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic [5:0] flags;  // {zero, neg, carry, full, empty, err}
  } exp_t;

  typedef struct {
    logic       v;
    acc_op_t    op;
    logic [7:0] d;
    logic       clr;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  acc_unit_if #(.WIDTH(8)) bus ();

  acc_unit #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp  = 0;
  int         n_fail = 0;
  exp_t       sb[$];
  exp_t       e;
  logic [7:0] m_acc;
  logic       m_carry;
  logic       m_err;
  logic [7:0] m_stk[$];

  function automatic void model_reset();
    m_acc   = 8'h00;
    m_carry = 1'b0;
    m_err   = 1'b0;
    m_stk   = {};
  endfunction

  function automatic void model_step(input logic v, input acc_op_t o,
                                     input logic [7:0] d, input logic clr);
    logic [8:0] s;
    logic       bad;
    exp_t       x;
    bad = 1'b0;
    if (v) begin
      case (o)
        OP_LOAD: m_acc = d;
        OP_ADD: begin
          s = {1'b0, m_acc} + {1'b0, d};
          m_carry = s[8];
`ifdef ACC_UNIT_SAT_EN
          m_acc = s[8] ? 8'hFF : s[7:0];
`else
          m_acc = s[7:0];
`endif
        end
        OP_SUB: begin
          m_carry = (d > m_acc);
`ifdef ACC_UNIT_SAT_EN
          m_acc = (d > m_acc) ? 8'h00 : m_acc - d;
`else
          m_acc = m_acc - d;
`endif
        end
        OP_AND: m_acc = m_acc & d;
        OP_XOR: m_acc = m_acc ^ d;
        OP_PUSH: if (m_stk.size() == 4) bad = 1'b1; else m_stk.push_back(m_acc);
        OP_POP:  if (m_stk.size() == 0) bad = 1'b1; else m_acc = m_stk.pop_back();
        default: ;
      endcase
    end
    if (bad) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    x.data  = m_acc;
    x.flags = {(m_acc == 8'h00), m_acc[7], m_carry, (m_stk.size() == 4),
               (m_stk.size() == 0), m_err};
    sb.push_back(x);
  endfunction

  task automatic drive(input stim_t s);
    bus.op_valid = s.v;
    bus.op       = s.op;
    bus.data_in  = s.d;
    bus.clr_err  = s.clr;
    model_step(s.v, s.op, s.d, s.clr);
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.clr_err  = 1'b0;
  endtask

  task automatic test_reset();
    stim_t t;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {8'h00, 6'b100010}) begin
      n_fail++;
      $display("FAIL reset_held: got data=%h z/n/c/f/e/err=%b%b%b%b%b%b, want data=00 100010",
               bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err);
    end
    rst_n = 1'b1;
    model_reset();
    t = '{1'b1, OP_LOAD, 8'h5A, 1'b0};
    drive(t);
    e = sb.pop_front();
    n_cmp++;
    if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {e.data, e.flags}) begin
      n_fail++;
      $display("FAIL reset_load: got data=%h, want data=%h flags=%b", bus.data_out, e.data, e.flags);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {8'h00, 6'b100010}) begin
      n_fail++;
      $display("FAIL reset_async: got data=%h z=%b e=%b, want data=00 z=1 e=1",
               bus.data_out, bus.zero, bus.empty);
    end
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_load_add();
    stim_t t [2];
    t = '{'{1'b1, OP_LOAD, 8'hAB, 1'b0}, '{1'b1, OP_ADD, 8'h60, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      drive(t[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {e.data, e.flags}) begin
        n_fail++;
        $display("FAIL load_add step %0d: got data=%h flags=%b%b%b%b%b%b, want data=%h flags=%b", i,
                 bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err, e.data, e.flags);
      end
    end
    n_cmp++;
`ifdef ACC_UNIT_SAT_EN
    if ({bus.data_out, bus.carry} !== {8'hFF, 1'b1}) begin
      n_fail++;
      $display("FAIL load_add_final: got data=%h carry=%b, want FF 1", bus.data_out, bus.carry);
    end
`else
    if ({bus.data_out, bus.carry} !== {8'h0B, 1'b1}) begin
      n_fail++;
      $display("FAIL load_add_final: got data=%h carry=%b, want 0B 1", bus.data_out, bus.carry);
    end
`endif
  endtask

  task automatic test_subtract();
    stim_t t [3];
    t = '{'{1'b1, OP_LOAD, 8'h10, 1'b0}, '{1'b1, OP_SUB, 8'h20, 1'b0},
          '{1'b1, OP_AND, 8'h0F, 1'b0}};
    for (int i = 0; i < 3; i++) begin
      drive(t[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {e.data, e.flags}) begin
        n_fail++;
        $display("FAIL subtract step %0d: got data=%h flags=%b%b%b%b%b%b, want data=%h flags=%b", i,
                 bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err, e.data, e.flags);
      end
    end
    n_cmp++;
    if ({bus.data_out, bus.zero, bus.carry} !== {8'h00, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL subtract_final: got data=%h zero=%b carry=%b, want 00 1 1",
               bus.data_out, bus.zero, bus.carry);
    end
  endtask

  task automatic test_stack();
    stim_t t [14];
    t = '{'{1'b1, OP_LOAD, 8'h11, 1'b0}, '{1'b1, OP_PUSH, 8'h00, 1'b0},
          '{1'b1, OP_LOAD, 8'h22, 1'b0}, '{1'b1, OP_PUSH, 8'h00, 1'b0},
          '{1'b1, OP_LOAD, 8'h33, 1'b0}, '{1'b1, OP_PUSH, 8'h00, 1'b0},
          '{1'b1, OP_LOAD, 8'h44, 1'b0}, '{1'b1, OP_PUSH, 8'h00, 1'b0},
          '{1'b1, OP_PUSH, 8'h00, 1'b0}, '{1'b1, OP_POP,  8'h00, 1'b0},
          '{1'b1, OP_POP,  8'h00, 1'b0}, '{1'b1, OP_POP,  8'h00, 1'b0},
          '{1'b1, OP_POP,  8'h00, 1'b0}, '{1'b1, OP_POP,  8'h00, 1'b0}};
    for (int i = 0; i < 14; i++) begin
      drive(t[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {e.data, e.flags}) begin
        n_fail++;
        $display("FAIL stack step %0d: got data=%h flags=%b%b%b%b%b%b, want data=%h flags=%b", i,
                 bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err, e.data, e.flags);
      end
    end
    n_cmp++;
    if ({bus.data_out, bus.empty, bus.full, bus.err} !== {8'h11, 1'b1, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL stack_final: got data=%h empty=%b full=%b err=%b, want 11 1 0 1",
               bus.data_out, bus.empty, bus.full, bus.err);
    end
  endtask

  task automatic test_sticky_err();
    stim_t t [2];
    t = '{'{1'b1, OP_POP, 8'h00, 1'b1}, '{1'b0, OP_NOP, 8'h00, 1'b1}};
    for (int i = 0; i < 2; i++) begin
      drive(t[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {e.data, e.flags}) begin
        n_fail++;
        $display("FAIL sticky_err step %0d: got data=%h err=%b, want data=%h flags=%b", i,
                 bus.data_out, bus.err, e.data, e.flags);
      end
    end
    n_cmp++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_err_clear: got err=%b, want 0", bus.err);
    end
  endtask

  task automatic test_back_to_back();
    stim_t t;
    for (int i = 0; i < 64; i++) begin
      if (i < 4) begin
        case (i)
          0: t = '{1'b1, OP_LOAD, 8'h77, 1'b0};
          1: t = '{1'b1, OP_PUSH, 8'h00, 1'b0};
          2: t = '{1'b1, OP_POP,  8'h00, 1'b0};
          default: t = '{1'b1, OP_XOR, 8'hFF, 1'b0};
        endcase
      end else begin
        t.v   = ($urandom_range(0, 7) != 0);
        t.op  = acc_op_t'($urandom_range(0, 7));
        t.d   = 8'($urandom);
        t.clr = ($urandom_range(0, 9) == 0);
      end
      drive(t);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {e.data, e.flags}) begin
        n_fail++;
        $display("FAIL back_to_back step %0d op=%0d d=%h: got data=%h flags=%b%b%b%b%b%b, want data=%h flags=%b",
                 i, t.op, t.d, bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err,
                 e.data, e.flags);
      end
    end
  endtask

  task automatic test_qualifier_reset();
    stim_t t [2];
    t = '{'{1'b1, OP_LOAD, 8'h3C, 1'b0}, '{1'b0, OP_LOAD, 8'h55, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      drive(t[i]);
      e = sb.pop_front();
      n_cmp++;
      if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {e.data, e.flags}) begin
        n_fail++;
        $display("FAIL qualifier step %0d: got data=%h, want data=%h flags=%b", i,
                 bus.data_out, e.data, e.flags);
      end
    end
    bus.op_valid = 1'b1;
    bus.op       = OP_LOAD;
    bus.data_in  = 8'hCC;
    #4 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_out, bus.zero, bus.neg, bus.carry, bus.full, bus.empty, bus.err} !== {8'h00, 6'b100010}) begin
      n_fail++;
      $display("FAIL midop_reset_async: got data=%h, want 00", bus.data_out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL midop_reset_discard: got data=%h, want 00", bus.data_out);
    end
    bus.op_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.data_in  = 8'h00;
    bus.clr_err  = 1'b0;
    model_reset();
    test_reset();
    test_load_add();
    test_subtract();
    test_stack();
    test_sticky_err();
    test_back_to_back();
    test_qualifier_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
